// File: rtl/irig_pkg.sv
// Shared encodings for the IRIG-B frame sequencer: symbol codes, error
// causes, FSM states and default frame geometry.
package irig_pkg;

  localparam int CNT_W_DEF         = 32;
  localparam int FRAME_BITS_DEF    = 100;
  localparam int MARK_INTERVAL_DEF = 10;

  // Classified pulse symbol
  typedef enum logic [1:0] {
    SYM_ZERO = 2'd0,
    SYM_ONE  = 2'd1,
    SYM_MARK = 2'd2
  } sym_e;

  // Error cause reported alongside the err pulse
  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_GLITCH  = 2'd1,
    ERR_MARK    = 2'd2,
    ERR_OVERRUN = 2'd3
  } err_e;

  // Frame alignment FSM states
  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_SYNC = 2'd1,
    ST_RECV = 2'd2
  } state_e;

endpackage

// File: rtl/irig_pulse_classifier.sv
// Measures the width of each high pulse on the sampled IRIG level and
// classifies it at the falling edge. Outputs are combinational pulses that
// are valid in the ce cycle that samples the falling edge; the sequencer
// registers them.
module irig_pulse_classifier
  import irig_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             gpio,
  input  logic [CNT_W-1:0] thr_one,
  input  logic [CNT_W-1:0] thr_mark,
  input  logic [CNT_W-1:0] max_high,
  output logic             sym_valid,
  output sym_e             sym,
  output logic             glitch
);

  logic             gpio_prev;
  logic [CNT_W-1:0] width;
  logic             fall;

  assign fall = ce && !gpio && gpio_prev;

  // Edge history and saturating high-time counter; the first high sample counts as 1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gpio_prev <= 1'b0;
      width     <= '0;
    end else if (ce) begin
      gpio_prev <= gpio;
      if (gpio && !gpio_prev) begin
        width <= CNT_W'(1);
      end else if (gpio && (width != '1)) begin
        width <= width + CNT_W'(1);
      end
    end
  end

  // Threshold compare on the falling edge; over-long pulses are glitches
  always_comb begin
    sym_valid = 1'b0;
    sym       = SYM_ZERO;
    glitch    = 1'b0;
    if (fall) begin
      if (width < thr_one) begin
        sym_valid = 1'b1;
        sym       = SYM_ZERO;
      end else if (width < thr_mark) begin
        sym_valid = 1'b1;
        sym       = SYM_ONE;
      end else if (width <= max_high) begin
        sym_valid = 1'b1;
        sym       = SYM_MARK;
      end else begin
        glitch    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irig_frame_sequencer.sv
// Locks onto the IRIG-B frame reference (two consecutive markers), checks
// the position-marker grid, assembles 100-symbol frames and hands them to
// the time decoder.
//
// Handshake: frame_valid rises when a completed frame is loaded into
// frame_data and stays high, with frame_data stable, until a cycle with
// frame_valid && frame_ready; that cycle is the transfer. A frame completing
// while an untransferred frame is held (and frame_ready is low) is dropped
// and reported as an overrun; the held frame is not disturbed.
module irig_frame_sequencer
  import irig_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int FRAME_BITS    = FRAME_BITS_DEF,
  parameter int MARK_INTERVAL = MARK_INTERVAL_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic                  gpio,
  input  logic [CNT_W-1:0]      thr_one,
  input  logic [CNT_W-1:0]      thr_mark,
  input  logic [CNT_W-1:0]      max_high,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  bit_valid,
  output logic [1:0]            bit_sym,
  output logic                  locked,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [1:0]            state_out
);

  localparam int IDX_W = $clog2(FRAME_BITS);
  localparam int GRP_W = $clog2(MARK_INTERVAL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);
  localparam logic [GRP_W-1:0] SLOT_POS = GRP_W'(MARK_INTERVAL - 1);

  state_e                 state;
  logic [IDX_W-1:0]       idx;
  logic [GRP_W-1:0]       grp;
  logic [FRAME_BITS-1:0]  acc;
  logic [FRAME_BITS-1:0]  acc_next;

  logic cls_valid;
  sym_e cls_sym;
  logic cls_glitch;

  logic is_mark;
  logic on_slot;
  logic slot_ok;
  logic last_sym;
  logic can_load;

  irig_pulse_classifier #(
    .CNT_W (CNT_W)
  ) u_classifier (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .gpio      (gpio),
    .thr_one   (thr_one),
    .thr_mark  (thr_mark),
    .max_high  (max_high),
    .sym_valid (cls_valid),
    .sym       (cls_sym),
    .glitch    (cls_glitch)
  );

  assign is_mark   = (cls_sym == SYM_MARK);
  assign on_slot   = (grp == SLOT_POS);
  assign slot_ok   = (on_slot == is_mark);
  assign last_sym  = (idx == LAST_IDX);
  assign can_load  = !frame_valid || frame_ready;
  assign state_out = state;

  // Frame accumulator with the current symbol written at its index
  always_comb begin
    acc_next      = acc;
    acc_next[idx] = (cls_sym == SYM_ONE);
  end

  // Alignment FSM, index/grid tracking, frame store and output handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_HUNT;
      idx         <= '0;
      grp         <= '0;
      acc         <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      bit_valid   <= 1'b0;
      bit_sym     <= 2'd0;
      locked      <= 1'b0;
      err         <= 1'b0;
      err_code    <= 2'd0;
    end else begin
      bit_valid <= 1'b0;
      err       <= 1'b0;

      if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end

      if (cls_valid) begin
        bit_valid <= 1'b1;
        bit_sym   <= cls_sym;
        case (state)
          ST_HUNT: begin
            locked <= 1'b0;
            if (is_mark) begin
              state <= ST_SYNC;
            end
          end
          ST_SYNC: begin
            if (is_mark) begin
              // This marker is Pr (index 0); next symbol is index 1
              state  <= ST_RECV;
              idx    <= IDX_W'(1);
              grp    <= GRP_W'(1);
              acc    <= '0;
              locked <= 1'b1;
            end else begin
              state  <= ST_HUNT;
              locked <= 1'b0;
            end
          end
          ST_RECV: begin
            if (!slot_ok) begin
              err      <= 1'b1;
              err_code <= ERR_MARK;
              state    <= ST_HUNT;
              locked   <= 1'b0;
            end else if (last_sym) begin
              // P0 closes the frame; the next marker must be Pr
              state <= ST_SYNC;
              if (can_load) begin
                frame_data  <= acc_next;
                frame_valid <= 1'b1;
              end else begin
                err      <= 1'b1;
                err_code <= ERR_OVERRUN;
              end
            end else begin
              acc <= acc_next;
              idx <= idx + IDX_W'(1);
              grp <= on_slot ? '0 : grp + GRP_W'(1);
            end
          end
          default: begin
            state  <= ST_HUNT;
            locked <= 1'b0;
          end
        endcase
      end else if (cls_glitch) begin
        err      <= 1'b1;
        err_code <= ERR_GLITCH;
        if (state != ST_HUNT) begin
          state  <= ST_HUNT;
          locked <= 1'b0;
        end
      end
    end
  end

endmodule
